// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve queue.
//   DEPTH_DEF : default number of queued predictions (power of two, >= 2)
//   CNT_W_DEF : default width of each statistics counter
//   PTR_W     : pointer width for the default depth
//   CNT_MAX   : saturation value for default-width counters
package branch_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 16;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage : branch_pkg

// File: rtl/branch_resolve_queue_if.sv
// Bus between the branch predictor / execute side and the resolve queue.
//   push, pred_in                : new prediction to record
//   resolve_valid, resolve_taken : oldest branch executed, with its outcome
//   full, empty, occupancy       : queue state (registered)
//   result, taken                : training pulse and actual outcome
//   mispredict, underflow        : one-cycle event pulses
//   resolved_cnt, mispred_cnt    : saturating statistics
// master = predictor/execute side, slave = queue.
interface branch_resolve_queue_if
    import branch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             push;
    logic             pred_in;
    logic             full;
    logic             empty;
    logic [OCC_W-1:0] occupancy;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic             underflow;
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output push, pred_in, resolve_valid, resolve_taken,
        input  full, empty, occupancy, result, taken, mispredict, underflow,
               resolved_cnt, mispred_cnt
    );

    modport slave (
        input  push, pred_in, resolve_valid, resolve_taken,
        output full, empty, occupancy, result, taken, mispredict, underflow,
               resolved_cnt, mispred_cnt
    );

endinterface : branch_resolve_queue_if

// File: rtl/pred_fifo.sv
// 1-bit-wide circular FIFO of predictions.
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write request and prediction bit
//   pop       : already-qualified pop of the head entry (caller guarantees !empty)
//   flush     : discard everything at this edge; a same-cycle push is dropped
//   head_bit  : oldest stored prediction
//   full, empty, occupancy : registered queue state
module pred_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      din,
    input  logic                      pop,
    input  logic                      flush,
    output logic                      head_bit,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_acc;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_acc = push && !flush && (!full_q || pop);

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;

        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push_acc) begin
            mem_d[tail_q] = din;
            tail_d        = tail_q + 1'b1;
        end

        case ({push_acc, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // Flush always coincides with a pop, so the new head is head_q+1.
        if (flush) begin
            tail_d = head_d;
            occ_d  = '0;
        end

        full_d  = (occ_d == OCC_FULL);
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Stored bits are only read behind a valid pointer, so no reset needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_bit  = mem_q[head_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign occupancy = occ_q;

endmodule : pred_fifo

// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions. Matches each executed
// branch outcome against the oldest stored prediction, emits registered
// training/mispredict/underflow pulses, flushes younger entries on a
// mispredict and keeps saturating resolve/mispredict counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolve_queue_if slave (see interface header)
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_resolve_queue_if.slave    bus
);
    localparam logic [CNT_W-1:0] SAT_MAX = {CNT_W{1'b1}};

    logic             head_bit;
    logic             fifo_empty;
    logic             resolve_acc;
    logic             mis_now;

    logic             result_q, result_d;
    logic             taken_q, taken_d;
    logic             mispredict_q, mispredict_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] resolved_q, resolved_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    assign resolve_acc = bus.resolve_valid && !fifo_empty;
    assign mis_now     = resolve_acc && (head_bit != bus.resolve_taken);

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.push),
        .din       (bus.pred_in),
        .pop       (resolve_acc),
        .flush     (mis_now),
        .head_bit  (head_bit),
        .full      (bus.full),
        .empty     (fifo_empty),
        .occupancy (bus.occupancy)
    );

    always_comb begin
        result_d     = resolve_acc;
        taken_d      = resolve_acc && bus.resolve_taken;
        mispredict_d = mis_now;
        underflow_d  = bus.resolve_valid && fifo_empty;

        resolved_d = resolved_q;
        if (resolve_acc && (resolved_q != SAT_MAX)) begin
            resolved_d = resolved_q + 1'b1;
        end

        mispred_d = mispred_q;
        if (mis_now && (mispred_q != SAT_MAX)) begin
            mispred_d = mispred_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q     <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
            resolved_q   <= '0;
            mispred_q    <= '0;
        end else begin
            result_q     <= result_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            underflow_q  <= underflow_d;
            resolved_q   <= resolved_d;
            mispred_q    <= mispred_d;
        end
    end

    assign bus.empty        = fifo_empty;
    assign bus.result       = result_q;
    assign bus.taken        = taken_q;
    assign bus.mispredict   = mispredict_q;
    assign bus.underflow    = underflow_q;
    assign bus.resolved_cnt = resolved_q;
    assign bus.mispred_cnt  = mispred_q;

endmodule : branch_resolve_queue

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a default instance (DEPTH=4,
// CNT_W=16) and a narrow-counter instance (CNT_W=2) for saturation and wrap.
module tb_branch_resolve_queue;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    branch_resolve_queue_if #(.DEPTH(4), .CNT_W(16)) bus ();
    branch_resolve_queue_if #(.DEPTH(4), .CNT_W(2))  sbus ();

    branch_resolve_queue #(.DEPTH(4), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    branch_resolve_queue #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle on the main instance; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic p, input logic pd, input logic rv, input logic rt);
        bus.push          = p;
        bus.pred_in       = pd;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic sstep(input logic p, input logic pd, input logic rv, input logic rt);
        sbus.push          = p;
        sbus.pred_in       = pd;
        sbus.resolve_valid = rv;
        sbus.resolve_taken = rt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [12:0] pat;
        n_tests = 0;
        n_fail  = 0;
        pat     = 13'b1011001110100;

        bus.push = 0; bus.pred_in = 0; bus.resolve_valid = 0; bus.resolve_taken = 0;
        sbus.push = 0; sbus.pred_in = 0; sbus.resolve_valid = 0; sbus.resolve_taken = 0;

        // Reset state
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_occ", 32'(bus.occupancy), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_mis", 32'(bus.mispredict), 0);
        chk("rst_resolved", 32'(bus.resolved_cnt), 0);

        // 1: correct predictions in order
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("t1_occ3", 32'(bus.occupancy), 3);
        chk("t1_result_idle", 32'(bus.result), 0);
        step(0, 0, 1, 1);
        chk("t1_r0_result", 32'(bus.result), 1);
        chk("t1_r0_taken", 32'(bus.taken), 1);
        chk("t1_r0_mis", 32'(bus.mispredict), 0);
        step(0, 0, 1, 0);
        chk("t1_r1_result", 32'(bus.result), 1);
        chk("t1_r1_taken", 32'(bus.taken), 0);
        chk("t1_r1_mis", 32'(bus.mispredict), 0);
        step(0, 0, 1, 1);
        chk("t1_r2_taken", 32'(bus.taken), 1);
        chk("t1_r2_mis", 32'(bus.mispredict), 0);
        chk("t1_resolved", 32'(bus.resolved_cnt), 3);
        chk("t1_mispred", 32'(bus.mispred_cnt), 0);
        chk("t1_empty", 32'(bus.empty), 1);
        step(0, 0, 0, 0);
        chk("t1_result_drop", 32'(bus.result), 0);

        // 2: mispredict flushes younger entries
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("t2_occ3", 32'(bus.occupancy), 3);
        step(0, 0, 1, 0);
        chk("t2_mis", 32'(bus.mispredict), 1);
        chk("t2_taken", 32'(bus.taken), 0);
        chk("t2_result", 32'(bus.result), 1);
        chk("t2_occ0", 32'(bus.occupancy), 0);
        chk("t2_empty", 32'(bus.empty), 1);
        chk("t2_mispred", 32'(bus.mispred_cnt), 1);
        chk("t2_resolved", 32'(bus.resolved_cnt), 4);
        step(0, 0, 0, 0);
        chk("t2_mis_drop", 32'(bus.mispredict), 0);

        // 3: full, dropped push, push+pop while full keeps order
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("t3_full", 32'(bus.full), 1);
        chk("t3_occ4", 32'(bus.occupancy), 4);
        step(1, 0, 0, 0);
        chk("t3_drop_occ", 32'(bus.occupancy), 4);
        chk("t3_drop_full", 32'(bus.full), 1);
        step(1, 1, 1, 1);
        chk("t3_pp_occ", 32'(bus.occupancy), 4);
        chk("t3_pp_mis", 32'(bus.mispredict), 0);
        chk("t3_pp_result", 32'(bus.result), 1);
        step(0, 0, 1, 0);
        chk("t3_d0_mis", 32'(bus.mispredict), 0);
        step(0, 0, 1, 0);
        chk("t3_d1_mis", 32'(bus.mispredict), 0);
        step(0, 0, 1, 1);
        chk("t3_d2_mis", 32'(bus.mispredict), 0);
        step(0, 0, 1, 1);
        chk("t3_d3_mis", 32'(bus.mispredict), 0);
        chk("t3_empty", 32'(bus.empty), 1);
        chk("t3_full_clr", 32'(bus.full), 0);
        chk("t3_resolved", 32'(bus.resolved_cnt), 9);
        chk("t3_mispred", 32'(bus.mispred_cnt), 1);

        // 4: underflow, then mispredict with simultaneous push
        step(0, 0, 1, 1);
        chk("t4_uf", 32'(bus.underflow), 1);
        chk("t4_uf_result", 32'(bus.result), 0);
        chk("t4_uf_resolved", 32'(bus.resolved_cnt), 9);
        chk("t4_uf_mispred", 32'(bus.mispred_cnt), 1);
        step(0, 0, 0, 0);
        chk("t4_uf_drop", 32'(bus.underflow), 0);
        step(1, 1, 0, 0);
        chk("t4_occ1", 32'(bus.occupancy), 1);
        step(1, 1, 1, 0);
        chk("t4_flush_mis", 32'(bus.mispredict), 1);
        chk("t4_flush_occ", 32'(bus.occupancy), 0);
        chk("t4_flush_empty", 32'(bus.empty), 1);
        chk("t4_mispred", 32'(bus.mispred_cnt), 2);
        chk("t4_resolved", 32'(bus.resolved_cnt), 10);

        // 5: reset mid-operation beats a resolve
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("t5_occ2", 32'(bus.occupancy), 2);
        rst = 1'b1;
        step(0, 0, 1, 1);
        rst = 1'b0;
        chk("t5_empty", 32'(bus.empty), 1);
        chk("t5_occ", 32'(bus.occupancy), 0);
        chk("t5_result", 32'(bus.result), 0);
        chk("t5_resolved", 32'(bus.resolved_cnt), 0);
        chk("t5_mispred", 32'(bus.mispred_cnt), 0);
        step(0, 0, 0, 0);
        chk("t5_result_after", 32'(bus.result), 0);
        chk("t5_uf_after", 32'(bus.underflow), 0);

        // 6: 2-bit counters saturate; pointers wrap many times
        for (int i = 0; i < 5; i++) begin
            sstep(1, 1, 0, 0);
            sstep(0, 0, 1, 0);
            chk("t6_mis_pulse", 32'(sbus.mispredict), 1);
        end
        chk("t6_mispred_sat", 32'(sbus.mispred_cnt), 3);
        chk("t6_resolved_sat", 32'(sbus.resolved_cnt), 3);
        for (int i = 0; i < 3; i++) begin
            sstep(1, pat[i], 0, 0);
        end
        chk("t6_occ3", 32'(sbus.occupancy), 3);
        for (int i = 3; i < 13; i++) begin
            sstep(1, pat[i], 1, pat[i-3]);
            chk("t6_wrap_mis", 32'(sbus.mispredict), 0);
            chk("t6_wrap_taken", 32'(sbus.taken), 32'(pat[i-3]));
            chk("t6_wrap_occ", 32'(sbus.occupancy), 3);
        end
        for (int i = 10; i < 13; i++) begin
            sstep(0, 0, 1, pat[i]);
            chk("t6_drain_mis", 32'(sbus.mispredict), 0);
        end
        chk("t6_empty", 32'(sbus.empty), 1);
        chk("t6_mispred_hold", 32'(sbus.mispred_cnt), 3);
        chk("t6_resolved_hold", 32'(sbus.resolved_cnt), 3);
        sstep(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_branch_resolve_queue
